// File: rtl/piso_serializer_mlane_pkg.sv
// Package for the multi-lane PISO serializer: shared width/order helpers
// and the shift-engine state encoding.
package piso_serializer_mlane_pkg;

`include "serializer_defs.vh"

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/piso_shift_lane.sv
// One serial lane: a DATA_W-bit shift register that loads a parallel word
// and shifts it toward its output end.
//   clk, rst   : clock, synchronous active-high reset
//   load       : capture load_data (has priority over shift)
//   shift      : move one bit toward the output end
//   load_data  : parallel word for this lane
//   ser_bit    : current output bit (MSB or LSB of the register)
module piso_shift_lane
    import piso_serializer_mlane_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] load_data,
    output logic              ser_bit
);

    logic [DATA_W-1:0] shreg_q;
    logic [DATA_W-1:0] shreg_d;

    always_comb begin
        shreg_d = shreg_q;
        if (load) begin
            shreg_d = load_data;
        end else if (shift) begin
            // Vacated positions fill with zero; they never reach the output
            // before the next load.
            if (MSB_FIRST == BIT_ORDER_LSB_FIRST) begin
                shreg_d = shreg_q >> 1;
            end else begin
                shreg_d = shreg_q << 1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    // The output bit comes straight from a flop, so ser_out is registered.
    assign ser_bit = (MSB_FIRST == BIT_ORDER_LSB_FIRST) ? shreg_q[0] : shreg_q[DATA_W-1];

endmodule

// File: rtl/serializer_defs.vh
// Shared definitions for the multi-lane PISO serializer.
//   clog2      : ceiling log2, usable in constant expressions
//   cnt_width  : bit-counter width for a given word width (never below 1)
//   BIT_ORDER_*: encodings for the shift direction parameter
`ifndef SERIALIZER_DEFS_VH
`define SERIALIZER_DEFS_VH

function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
        if ((1 << i) < value) begin
            r = i + 1;
        end
    end
    return r;
endfunction

function automatic int cnt_width(input int data_w);
    return (clog2(data_w) < 1) ? 1 : clog2(data_w);
endfunction

localparam bit BIT_ORDER_MSB_FIRST = 1'b1;
localparam bit BIT_ORDER_LSB_FIRST = 1'b0;

`endif

// File: rtl/piso_serializer_mlane.sv
// Multi-lane parallel-in/serial-out serializer with a one-word holding
// buffer (gapless back-to-back words) and a bit-rate enable.
//   clk, rst    : clock, synchronous active-high reset
//   bit_en      : shift engine advances only on edges with bit_en=1
//   s_data      : LANES words; lane k at [k*DATA_W +: DATA_W]
//   s_valid     : source word available
//   s_ready     : holding buffer empty (register-derived)
//   ser_out     : one registered serial bit per lane
//   ser_valid   : ser_out carries a valid bit
//   frame_start : first bit of a word
//   frame_end   : last bit of a word
//   busy        : engine shifting or holding buffer occupied
module piso_serializer_mlane
    import piso_serializer_mlane_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int LANES     = 1,
    parameter int MSB_FIRST = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    bit_en,
    input  logic [LANES*DATA_W-1:0] s_data,
    input  logic                    s_valid,
    output logic                    s_ready,
    output logic [LANES-1:0]        ser_out,
    output logic                    ser_valid,
    output logic                    frame_start,
    output logic                    frame_end,
    output logic                    busy
);

    localparam int               CNT_W      = cnt_width(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(DATA_W - 1);
    localparam bit               LANE_ORDER = (MSB_FIRST != 0) ? BIT_ORDER_MSB_FIRST
                                                               : BIT_ORDER_LSB_FIRST;

    state_e                  state_q, state_d;
    logic [LANES*DATA_W-1:0] hold_reg_q, hold_reg_d;
    logic                    hold_full_q, hold_full_d;
    logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic                    ser_valid_q, ser_valid_d;
    logic                    frame_start_q, frame_start_d;
    logic                    frame_end_q, frame_end_d;
    logic                    accept;
    logic                    last_bit;
    logic                    load_en;
    logic                    shift_en;

    // NOTE: every signal assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        accept      = s_valid & ~hold_full_q;
        last_bit    = (bit_cnt_q == LAST_BIT);
        load_en     = 1'b0;
        shift_en    = 1'b0;
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        hold_full_d = hold_full_q;
        hold_reg_d  = hold_reg_q;

        // Accept and reload never coincide: reload needs hold_full_q=1,
        // which holds s_ready low on that edge.
        if (accept) begin
            hold_reg_d  = s_data;
            hold_full_d = 1'b1;
        end

        if (bit_en) begin
            case (state_q)
                ST_IDLE: begin
                    if (hold_full_q) begin
                        load_en     = 1'b1;
                        hold_full_d = 1'b0;
                        bit_cnt_d   = '0;
                        state_d     = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (!last_bit) begin
                        shift_en  = 1'b1;
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end else if (hold_full_q) begin
                        // Gapless reload: next word's first bit follows the
                        // current word's last bit directly.
                        load_en     = 1'b1;
                        hold_full_d = 1'b0;
                        bit_cnt_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Flags are computed from next-state values so the registered
        // copies line up with the bit they describe.
        ser_valid_d   = (state_d == ST_SHIFT);
        frame_start_d = ser_valid_d & (bit_cnt_d == '0);
        frame_end_d   = ser_valid_d & (bit_cnt_d == LAST_BIT);
    end

    // NOTE: state updates use non-blocking assignments so every flop samples
    // values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the holding buffer is a plain register, not a memory, and
            // is cleared so a reset drops the held word deterministically.
            state_q       <= ST_IDLE;
            hold_reg_q    <= '0;
            hold_full_q   <= 1'b0;
            bit_cnt_q     <= '0;
            ser_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_reg_q    <= hold_reg_d;
            hold_full_q   <= hold_full_d;
            bit_cnt_q     <= bit_cnt_d;
            ser_valid_q   <= ser_valid_d;
            frame_start_q <= frame_start_d;
            frame_end_q   <= frame_end_d;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        piso_shift_lane #(
            .DATA_W    (DATA_W),
            .MSB_FIRST (LANE_ORDER)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .load      (load_en),
            .shift     (shift_en),
            .load_data (hold_reg_q[k*DATA_W +: DATA_W]),
            .ser_bit   (ser_out[k])
        );
    end

    assign s_ready     = ~hold_full_q;
    assign ser_valid   = ser_valid_q;
    assign frame_start = frame_start_q;
    assign frame_end   = frame_end_q;
    assign busy        = ser_valid_q | hold_full_q;

endmodule
